// File: rtl/multicore_input_dispatcher_pkg.sv
// Shared defaults, FSM encoding and sizing helper for the multicore input dispatcher.
package multicore_input_dispatcher_pkg;

    localparam int NUM_CORES_DEF     = 4;
    localparam int ELEM_PER_CORE_DEF = 4;
    localparam int DATA_W_DEF        = 4;
    localparam int SW_W              = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        ADVANCE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multicore_input_dispatcher_sw_edge_detect.sv
// Two-flop synchronizer for the switch bank plus a release (1->0) detector on bit 0.
module sw_edge_detect
    import multicore_input_dispatcher_pkg::*;
#(
    parameter int W = SW_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw,
    output logic [W-2:0] sw_data,
    output logic         release_evt
);

    logic [W-1:0] sync_q;
    logic [W-1:0] sync_qq;
    logic         btn_prev;

    // btn_prev resets low, so a button already held at reset release only fires on its next release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            sync_qq  <= '0;
            btn_prev <= 1'b0;
        end else begin
            sync_q   <= sw;
            sync_qq  <= sync_q;
            btn_prev <= sync_qq[0];
        end
    end

    assign sw_data     = sync_qq[W-1:1];
    assign release_evt = btn_prev & ~sync_qq[0];

endmodule

// File: rtl/multicore_input_dispatcher.sv
// Loads switch-entered elements one at a time into NUM_CORES cores, block-distributed,
// with a valid/ack handshake per element.
module multicore_input_dispatcher
    import multicore_input_dispatcher_pkg::*;
#(
    parameter int NUM_CORES     = NUM_CORES_DEF,
    parameter int ELEM_PER_CORE = ELEM_PER_CORE_DEF,
    parameter int DATA_W        = DATA_W_DEF
) (
    input  logic                 Clock_pin,
    input  logic                 Resetn_pin,
    input  logic [4:0]           SW_pin,
    output logic [DATA_W-1:0]    Data_core,
    output logic [NUM_CORES-1:0] Valid_core,
    input  logic [NUM_CORES-1:0] Ack_core,
    output logic                 Load_done,
    output logic [7:0]           Display_pin
);

    localparam int CW = cnt_w(NUM_CORES);
    localparam int EW = cnt_w(ELEM_PER_CORE);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   core_idx;
    logic [EW-1:0]   elem_cnt;
    logic [3:0]      sw_data;
    logic            release_evt;
    logic            ack_hit;
    logic            elem_last;
    logic            core_last;

    sw_edge_detect #(.W(SW_W)) u_sw (
        .clk         (Clock_pin),
        .rst_n       (Resetn_pin),
        .sw          (SW_pin),
        .sw_data     (sw_data),
        .release_evt (release_evt)
    );

    assign ack_hit   = Ack_core[core_idx];
    assign elem_last = (elem_cnt == EW'(ELEM_PER_CORE - 1));
    assign core_last = (core_idx == CW'(NUM_CORES - 1));

    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (release_evt) state_nxt = SEND;
            SEND:    if (ack_hit)     state_nxt = ADVANCE;
            ADVANCE: state_nxt = (elem_last && core_last) ? DONE : IDLE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Valid is decoded from the state register so reset removes it without waiting for a clock
    always_comb begin
        Valid_core = '0;
        if (state == SEND) Valid_core[core_idx] = 1'b1;
        Load_done = (state == DONE);
    end

    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            core_idx    <= '0;
            elem_cnt    <= '0;
            Data_core   <= '0;
            Display_pin <= '0;
        end else begin
            if (state == IDLE && release_evt) Data_core <= DATA_W'(sw_data);
            // The final element leaves both counters parked on the last core
            if (state == ADVANCE && !(elem_last && core_last)) begin
                if (elem_last) begin
                    elem_cnt <= '0;
                    core_idx <= core_idx + CW'(1);
                end else begin
                    elem_cnt <= elem_cnt + EW'(1);
                end
            end
            Display_pin <= {Load_done, 2'(core_idx), (state == SEND), 4'(Data_core)};
        end
    end

endmodule

// File: tb/tb_multicore_input_dispatcher.sv
// Directed bench for multicore_input_dispatcher: handshake, drops, reset and full load.
module tb_multicore_input_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] sw;
    logic [3:0] data;
    logic [3:0] valid;
    logic [3:0] ack;
    logic       done;
    logic [7:0] disp;
    logic [3:0] exp_v;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicore_input_dispatcher #(
        .NUM_CORES(4), .ELEM_PER_CORE(4), .DATA_W(4)
    ) dut (
        .Clock_pin   (clk),
        .Resetn_pin  (rst_n),
        .SW_pin      (sw),
        .Data_core   (data),
        .Valid_core  (valid),
        .Ack_core    (ack),
        .Load_done   (done),
        .Display_pin (disp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press, hold long enough to pass the synchronizer, then release with the value held
    task automatic press(input logic [3:0] v);
        sw = {v, 1'b1};
        tick(4);
        sw = {v, 1'b0};
    endtask

    task automatic ack_pulse(input logic [3:0] a);
        ack = a;
        tick(2);
        ack = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = '0;
        ack   = '0;
        tick(2);
        check("rst_valid", valid, 0);
        check("rst_data",  data,  0);
        check("rst_done",  done,  0);
        check("rst_disp",  disp,  0);
        rst_n = 1'b1;
        tick(2);

        // Element 0: value A, core 0 acks three cycles after valid
        press(4'hA);
        tick(2);
        check("latency_not_yet", valid, 0);
        tick(1);
        check("e0_valid", valid, 4'b0001);
        check("e0_data",  data,  4'hA);
        tick(1);
        check("e0_disp",  disp,  8'h1A);
        tick(1);
        check("e0_hold_valid", valid, 4'b0001);
        check("e0_hold_data",  data,  4'hA);
        ack = 4'b0001;
        tick(1);
        check("e0_valid_drop", valid, 0);
        tick(1);
        ack = '0;

        // Element 1: ack on the wrong core is ignored
        press(4'hB);
        tick(3);
        check("e1_valid", valid, 4'b0001);
        ack = 4'b0010;
        tick(3);
        check("wrong_ack_valid", valid, 4'b0001);
        check("wrong_ack_data",  data,  4'hB);
        ack_pulse(4'b0001);

        // Element 2: a second press during SEND is dropped
        press(4'hC);
        tick(3);
        check("e2_data", data, 4'hC);
        press(4'hD);
        tick(4);
        check("drop_data",  data,  4'hC);
        check("drop_valid", valid, 4'b0001);
        check("drop_disp",  disp,  8'h1C);
        ack_pulse(4'b0001);

        press(4'h3);
        tick(3);
        ack_pulse(4'b0001);

        // Element 4 crosses into core 1
        press(4'h4);
        tick(3);
        check("e4_valid", valid, 4'b0010);
        ack_pulse(4'b0010);

        // Element 5 in flight when reset hits; button held through reset release
        press(4'h5);
        tick(3);
        check("e5_valid", valid, 4'b0010);
        check("e5_data",  data,  4'h5);
        #2;
        rst_n = 1'b0;
        sw    = 5'b00001;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_data",  data,  0);
        check("midrst_disp",  disp,  0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("held_btn_no_evt", valid, 0);

        // Full load of 16 elements, values 0..15, block-distributed
        for (int n = 0; n < 16; n++) begin
            if (n == 0) sw = 5'b00000;
            else        press(4'(n));
            tick(3);
            exp_v = 4'b0001 << (n / 4);
            check($sformatf("load%0d_valid", n), valid, exp_v);
            check($sformatf("load%0d_data",  n), data,  n);
            ack = exp_v;
            tick(1);
            check($sformatf("load%0d_drop", n), valid, 0);
            tick(1);
            ack = '0;
            check($sformatf("load%0d_done", n), done, (n == 15) ? 1 : 0);
        end
        tick(1);
        check("final_valid", valid, 0);
        check("final_disp7", disp[7], 1);
        check("final_disp_bits", disp & 8'h9F, 8'h8F);

        // Press after completion changes nothing
        press(4'h7);
        for (int c = 0; c < 6; c++) begin
            tick(1);
            check($sformatf("post_done_valid%0d", c), valid, 0);
        end
        check("post_done_data", data, 4'hF);
        check("post_done_done", done, 1);
        check("post_done_disp", disp & 8'h9F, 8'h8F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
